// File: rtl/elevator_request_queue_pkg.sv
// Shared types for the elevator request path: floor count, one-hot floor
// type, scheduler state encoding and nearest-floor selection helpers.
package elevator_request_queue_pkg;

   localparam int NUM_FLOORS = 4;

   typedef logic [NUM_FLOORS-1:0] floor_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UP    = 2'd1,
      DOWN  = 2'd2,
      DWELL = 2'd3
   } state_t;

   // cur is one-hot: cur - 1 masks every floor below it
   function automatic floor_t lowest_above(floor_t req, floor_t cur);
      floor_t above;
      above = req & ~(cur | (cur - floor_t'(1)));
      return above & (~above + floor_t'(1));
   endfunction

   function automatic floor_t highest_below(floor_t req, floor_t cur);
      floor_t below;
      floor_t sel;
      below = req & (cur - floor_t'(1));
      sel   = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (below[i]) sel = floor_t'(1) << i;
      end
      return sel;
   endfunction

endpackage

// File: rtl/elevator_request_queue_btn_debounce.sv
// One floor button: two-flop synchronizer followed by a stable-high counter
// that emits a single-cycle request when the level has held long enough.
module btn_debounce
   import elevator_request_queue_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic btn,
   output logic req
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] stable_cnt;

   // Counter saturates at CNT_MAX so a held button fires only once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         stable_cnt <= '0;
         req        <= 1'b0;
      end else if (ena) begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         if (sync_p1) begin
            if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
            req <= (stable_cnt == CNT_MAX - 1'b1);
         end else begin
            stable_cnt <= '0;
            req        <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/elevator_request_queue.sv
// Floor request queue and travel scheduler: debounces buttons, latches
// pending floors and steers the car controller with a registered target.
module elevator_request_queue
   import elevator_request_queue_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DWELL_CYCLES    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic [NUM_FLOORS-1:0] cur_floor,
   output logic [NUM_FLOORS-1:0] target,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  moving_up
);

   localparam int              DW_W       = $clog2(DWELL_CYCLES + 1);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

   floor_t          req;
   state_t          state;
   logic [DW_W-1:0] dwell_cnt;

   logic   cur_valid;
   logic   dwell_last;
   logic   restart;
   floor_t pending_nxt;
   floor_t up_sel;
   floor_t dn_sel;
   floor_t up_exit;
   floor_t dn_exit;

   for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst_n(rst_n),
         .ena  (ena),
         .btn  (btn[i]),
         .req  (req[i])
      );
   end

   // A fresh request for the served floor beats the end-of-dwell clear
   always_comb begin
      cur_valid   = $onehot(cur_floor);
      dwell_last  = (state == DWELL) && (dwell_cnt == DWELL_LAST) && cur_valid;
      restart     = dwell_last && |(req & cur_floor);
      pending_nxt = (pending & ~(dwell_last ? cur_floor : floor_t'(0))) | req;
      up_sel      = lowest_above(pending, cur_floor);
      dn_sel      = highest_below(pending, cur_floor);
      up_exit     = lowest_above(pending_nxt, cur_floor);
      dn_exit     = highest_below(pending_nxt, cur_floor);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         target    <= floor_t'(1);
         door_open <= 1'b0;
         moving_up <= 1'b1;
         dwell_cnt <= '0;
      end else if (ena) begin
         pending <= pending_nxt;
         if (cur_valid) begin
            case (state)
               IDLE: begin
                  target <= cur_floor;
                  if (|(pending & cur_floor)) begin
                     state     <= DWELL;
                     door_open <= 1'b1;
                     dwell_cnt <= '0;
                  end else if (|up_sel) begin
                     state     <= UP;
                     moving_up <= 1'b1;
                     target    <= up_sel;
                  end else if (|dn_sel) begin
                     state     <= DOWN;
                     moving_up <= 1'b0;
                     target    <= dn_sel;
                  end
               end
               UP: begin
                  if (cur_floor == target) begin
                     state     <= DWELL;
                     door_open <= 1'b1;
                     dwell_cnt <= '0;
                  end else if (|up_sel) begin
                     target <= up_sel;
                  end
               end
               DOWN: begin
                  if (cur_floor == target) begin
                     state     <= DWELL;
                     door_open <= 1'b1;
                     dwell_cnt <= '0;
                  end else if (|dn_sel) begin
                     target <= dn_sel;
                  end
               end
               DWELL: begin
                  target <= cur_floor;
                  if (dwell_cnt != DWELL_LAST) begin
                     dwell_cnt <= dwell_cnt + 1'b1;
                  end else if (restart) begin
                     dwell_cnt <= '0;
                  end else begin
                     // Keep heading the same way while work remains there
                     door_open <= 1'b0;
                     if (moving_up && |up_exit) begin
                        state  <= UP;
                        target <= up_exit;
                     end else if (!moving_up && |dn_exit) begin
                        state  <= DOWN;
                        target <= dn_exit;
                     end else if (|up_exit) begin
                        state     <= UP;
                        moving_up <= 1'b1;
                        target    <= up_exit;
                     end else if (|dn_exit) begin
                        state     <= DOWN;
                        moving_up <= 1'b0;
                        target    <= dn_exit;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: vector table, directed corner sequences
// and a randomized run against a floor-index reference model.
module tb_elevator_request_queue;

   localparam int DEB = 4;
   localparam int DW  = 8;

   localparam int S_IDLE  = 0;
   localparam int S_UP    = 1;
   localparam int S_DOWN  = 2;
   localparam int S_DWELL = 3;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [3:0] btn;
   logic [3:0] cur_floor;
   logic [3:0] target;
   logic [3:0] pending;
   logic       door_open;
   logic       moving_up;

   int n_cmp;
   int n_err;

   elevator_request_queue #(
      .DEBOUNCE_CYCLES(DEB),
      .DWELL_CYCLES   (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .btn      (btn),
      .cur_floor(cur_floor),
      .target   (target),
      .pending  (pending),
      .door_open(door_open),
      .moving_up(moving_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] btn;
      logic [3:0] cur;
      logic [3:0] exp_pend;
      logic [3:0] exp_tgt;
      logic       exp_door;
      logic       exp_up;
   } vec_t;

   vec_t vecs[$];

   // reference model state: floors as indices 0..3
   bit [3:0] m_pend;
   bit [3:0] m_req;
   int       m_tgt;
   int       m_st;
   int       m_dc;
   bit       m_door;
   bit       m_up;
   bit       m_sy1[4];
   bit       m_sy2[4];
   int       m_run[4];

   function automatic vec_t mk(logic r, logic [3:0] b, logic [3:0] c, logic [3:0] p,
                               logic [3:0] t, logic d, logic u);
      vec_t v;
      v.rst_n = r; v.btn = b; v.cur = c;
      v.exp_pend = p; v.exp_tgt = t; v.exp_door = d; v.exp_up = u;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic [3:0] b, input logic [3:0] c);
      btn = b;
      cur_floor = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ena = 1'b1;
      btn = 4'b0000;
      cur_floor = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int floor_index(logic [3:0] f);
      int idx = -1;
      int cnt = 0;
      for (int i = 0; i < 4; i++) if (f[i]) begin idx = i; cnt++; end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic int nearest_above(bit [3:0] p, int cf);
      for (int f = cf + 1; f < 4; f++) if (p[f]) return f;
      return -1;
   endfunction

   function automatic int nearest_below(bit [3:0] p, int cf);
      for (int f = cf - 1; f >= 0; f--) if (p[f]) return f;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_req = '0; m_tgt = 0; m_st = S_IDLE; m_dc = 0;
      m_door = 1'b0; m_up = 1'b1;
      for (int i = 0; i < 4; i++) begin m_sy1[i] = 0; m_sy2[i] = 0; m_run[i] = 0; end
   endtask

   task automatic open_door();
      m_st = S_DWELL; m_door = 1'b1; m_dc = 0;
   endtask

   task automatic model_step();
      int cf;
      int la;
      int hb;
      bit [3:0] np;
      bit [3:0] nreq;
      bit last;
      if (!ena) return;
      cf = floor_index(cur_floor);
      last = (m_st == S_DWELL) && (cf >= 0) && (m_dc == DW - 1);
      np = m_pend;
      if (last) np[cf] = 1'b0;
      np = np | m_req;
      if (cf >= 0) begin
         case (m_st)
            S_IDLE: begin
               m_tgt = cf;
               la = nearest_above(m_pend, cf);
               hb = nearest_below(m_pend, cf);
               if (m_pend[cf]) open_door();
               else if (la >= 0) begin m_st = S_UP; m_up = 1'b1; m_tgt = la; end
               else if (hb >= 0) begin m_st = S_DOWN; m_up = 1'b0; m_tgt = hb; end
            end
            S_UP: begin
               if (cf == m_tgt) open_door();
               else begin la = nearest_above(m_pend, cf); if (la >= 0) m_tgt = la; end
            end
            S_DOWN: begin
               if (cf == m_tgt) open_door();
               else begin hb = nearest_below(m_pend, cf); if (hb >= 0) m_tgt = hb; end
            end
            default: begin
               m_tgt = cf;
               if (!last) m_dc++;
               else if (m_req[cf]) m_dc = 0;
               else begin
                  m_door = 1'b0;
                  la = nearest_above(np, cf);
                  hb = nearest_below(np, cf);
                  if (m_up && la >= 0) begin m_st = S_UP; m_tgt = la; end
                  else if (!m_up && hb >= 0) begin m_st = S_DOWN; m_tgt = hb; end
                  else if (la >= 0) begin m_st = S_UP; m_up = 1'b1; m_tgt = la; end
                  else if (hb >= 0) begin m_st = S_DOWN; m_up = 1'b0; m_tgt = hb; end
                  else m_st = S_IDLE;
               end
            end
         endcase
      end
      // a request registers when the synchronized level completes DEB high cycles
      for (int i = 0; i < 4; i++) begin
         nreq[i] = m_sy2[i] && (m_run[i] + 1 == DEB);
         m_run[i] = m_sy2[i] ? m_run[i] + 1 : 0;
         m_sy2[i] = m_sy1[i];
         m_sy1[i] = btn[i];
      end
      m_pend = np;
      m_req = nreq;
   endtask

   initial begin
      int door_cnt;
      int car;
      logic [3:0] b;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      ena = 1'b1;
      btn = 4'b0000;
      cur_floor = 4'b0001;
      @(negedge clk);

      // reset, a 3-cycle glitch, then a held request served at floor 3
      vecs.push_back(mk(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1'b1, 4'b0100, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1));
      for (int k = 1; k <= 6; k++) vecs.push_back(mk(1'b1, 4'b0100, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 1'b0, 1'b1));
      for (int k = 8; k <= 10; k++) vecs.push_back(mk(1'b1, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 1'b0, 1'b1));
      for (int k = 12; k <= 19; k++) vecs.push_back(mk(1'b1, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1));
      for (int k = 20; k <= 21; k++) vecs.push_back(mk(1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1));

      foreach (vecs[k]) begin
         rst_n = vecs[k].rst_n;
         cyc(vecs[k].btn, vecs[k].cur);
         check($sformatf("vec%0d", k), 32'({pending, target, door_open, moving_up}),
               32'({vecs[k].exp_pend, vecs[k].exp_tgt, vecs[k].exp_door, vecs[k].exp_up}));
      end

      // same-floor request landing on the last dwell cycle restarts the dwell
      door_cnt = 0;
      for (int j = 1; j <= 30; j++) begin
         b = ((j <= 6) || (j >= 10 && j <= 15)) ? 4'b0100 : 4'b0000;
         cyc(b, 4'b0100);
         if (door_open) door_cnt++;
         if (j == 8) check("dwell_enter", 32'(door_open), 32'd1);
         if (j == 16) check("restart_keep_pend", 32'(pending), 32'h4);
         if (j == 24) check("restart_clear_pend", 32'(pending), 32'h0);
      end
      check("restart_door_len", 32'(door_cnt), 32'd16);

      // at floor 2 going up with floors 1 and 4 pending: serve 4 first, then reverse
      do_reset();
      repeat (6) cyc(4'b0010, 4'b0001);
      cyc(4'b0000, 4'b0001);
      cyc(4'b0000, 4'b0001);
      check("go_up_floor2", 32'({target, moving_up}), 32'({4'b0010, 1'b1}));
      cyc(4'b0000, 4'b0010);
      repeat (6) cyc(4'b1001, 4'b0010);
      repeat (2) cyc(4'b0000, 4'b0010);
      check("continue_up", 32'({pending, target, door_open, moving_up}),
            32'({4'b1001, 4'b1000, 1'b0, 1'b1}));
      repeat (3) cyc(4'b0000, 4'b0100);
      check("passing_floor3", 32'({target, moving_up}), 32'({4'b1000, 1'b1}));
      cyc(4'b0000, 4'b1000);
      check("arrive_floor4", 32'(door_open), 32'd1);
      repeat (9) cyc(4'b0000, 4'b1000);
      check("reverse_down", 32'({pending, target, door_open, moving_up}),
            32'({4'b0001, 4'b0001, 1'b0, 1'b0}));

      // asynchronous reset mid-dwell, then no early re-registration
      do_reset();
      repeat (8) cyc(4'b1010, 4'b0010);
      repeat (3) cyc(4'b1010, 4'b0010);
      check("pre_reset", 32'({pending, door_open}), 32'({4'b1010, 1'b1}));
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'({pending, target, door_open, moving_up}),
            32'({4'b0000, 4'b0001, 1'b0, 1'b1}));
      @(negedge clk);
      cyc(4'b1010, 4'b0010);
      rst_n = 1'b1;
      for (int k = 1; k <= DEB + 2; k++) begin
         cyc(4'b1010, 4'b0010);
         check($sformatf("no_early_req%0d", k), 32'(pending), 32'h0);
      end
      cyc(4'b1010, 4'b0010);
      check("req_after_reset", 32'(pending), 32'hA);

      // randomized run against the reference model
      do_reset();
      model_reset();
      car = 0;
      for (int n = 0; n < 3000; n++) begin
         check("rand_out", 32'({pending, target, door_open, moving_up}),
               32'({m_pend, 4'(1 << m_tgt), m_door, m_up}));
         if (n == 1500) rst_n = 1'b0;
         if (n == 1502) rst_n = 1'b1;
         ena = ($urandom_range(0, 19) != 0);
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
         if ((m_st == S_UP || m_st == S_DOWN) && car != m_tgt && (n % 3) == 0)
            car += (m_tgt > car) ? 1 : -1;
         cur_floor = 4'(1 << car);
         if ($urandom_range(0, 29) == 0)
            cur_floor = ($urandom_range(0, 1) != 0) ? 4'b0000 : (cur_floor | 4'(1 << ((car + 1) % 4)));
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/elevator_request_queue.md
ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, cycles a button must be stable high before it registers as a request.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 32, number of cycles the door stays open at a served floor.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port ena  input  1  when low, all state SHALL hold; outputs unchanged.
REQ-006 Port btn  input  4  raw asynchronous floor-request buttons, bit i = floor i+1, active high.
REQ-007 Port cur_floor  input  4  one-hot current floor from the downstream car controller.
REQ-008 Port target  output  4  one-hot floor the car controller SHALL move toward.
REQ-009 Port pending  output  4  latched outstanding requests, bit i = floor i+1.
REQ-010 Port door_open  output  1  high for exactly DWELL_CYCLES cycles while a floor is served.
REQ-011 Port moving_up  output  1  current/last travel direction, 1 = up.

Function
REQ-012 Each btn bit SHALL pass a 2-flop synchronizer, then a per-bit stable counter; a request SHALL register once, when the synchronized bit has been high for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 A bit held high SHALL NOT re-register until it has gone low and satisfied REQ-012 again.
REQ-014 A registered request SHALL set the matching pending bit on the next cycle; pending bits are sticky until cleared by REQ-020.
REQ-015 FSM states SHALL be IDLE, UP, DOWN, DWELL.
REQ-016 IDLE: target = cur_floor; if the pending bit at cur_floor is set -> DWELL; else if any pending above cur_floor -> UP; else if any pending below -> DOWN; else stay.
REQ-017 UP: target SHALL be the lowest pending floor strictly above cur_floor; DOWN: target SHALL be the highest pending floor strictly below cur_floor; target SHALL update combinationally-registered with one-cycle latency from pending/cur_floor change.
REQ-018 UP/DOWN -> DWELL on the first cycle cur_floor equals target.
REQ-019 DWELL: door_open = 1, target = cur_floor, counter runs DWELL_CYCLES cycles.
REQ-020 On the last DWELL cycle the pending bit for cur_floor SHALL clear; if a registered request for the same floor arrives that same cycle, set SHALL win and DWELL SHALL restart.
REQ-021 DWELL exit: pending in moving_up direction -> continue that direction; else pending in opposite direction -> reverse (moving_up toggles); else -> IDLE.
REQ-022 moving_up SHALL change only on entry to UP (1) or DOWN (0).
REQ-023 If cur_floor is not one-hot (zero or multiple bits) the FSM and target SHALL hold; pending SHALL still accept new requests.
REQ-024 A pending bit becoming set for a floor passed in the current direction SHALL NOT alter direction; it is served after reversal.

Reset
REQ-025 While rst_n low: state = IDLE, pending = 4'b0000, target = 4'b0001, door_open = 0, moving_up = 1, synchronizers, debounce and dwell counters = 0.
REQ-026 Reset mid-DWELL or mid-travel SHALL drop all pending requests; no request SHALL register within DEBOUNCE_CYCLES+2 cycles after release.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration, NUM_FLOORS = 4 and the one-hot floor type, for reuse by the car controller.
REQ-028 Debounce SHALL be one sub-module, btn_debounce, instantiated once per button bit.
REQ-029 Target selection (nearest above/below) SHALL be purely combinational from pending and cur_floor, registered once.

Verification (DEBOUNCE_CYCLES=4, DWELL_CYCLES=8)
REQ-030 cur_floor=0001, btn[2] high 10 cycles -> pending=0100 after 7 cycles, state UP, target=0100, moving_up=1.
REQ-031 btn[2] high for 3 cycles only (glitch) -> pending stays 0000, target stays 0001.
REQ-032 Car at 0100 with target 0100 -> door_open high exactly 8 cycles, pending bit 2 clears on last, then IDLE.
REQ-033 At floor 2 moving up, pending=1001 -> serve 1000 first (UP), then reverse, moving_up=0, target=0001.
REQ-034 Request at cur_floor arriving on last DWELL cycle -> pending bit stays set, DWELL restarts for 8 more cycles.
REQ-035 rst_n pulsed low mid-DWELL with pending=1010 -> pending=0000, door_open=0, target=0001 immediately (async).
